// File: rtl/hazard_flush_ctrl.sv
// Pipeline sequencer: load-use stalls, branch/jump redirects and flush
// windows, multi-cycle EX holds, plus saturating redirect/stall counters.
module hazard_flush_ctrl #(
  parameter int REG_W        = 5,
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic [PC_W-1:0]  ex_branch_target,
  input  logic             id_jump,
  input  logic [PC_W-1:0]  id_jump_target,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             flush_if,
  output logic             flush_id,
  output logic             ex_bubble,
  output logic             ex_hold,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] redirect_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_MC    = 2'd2;

  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [3:0] FLUSH_INIT  = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  assign ctrl_state = state_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    flush_if       = 1'b0;
    flush_id       = 1'b0;
    ex_bubble      = 1'b0;
    ex_hold        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (rst) begin
      state_d     = ST_RUN;
      cnt_d       = '0;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      flush_if    = 1'b1;
      flush_id    = 1'b1;
      ex_bubble   = 1'b1;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          // Everything younger than the branch is being squashed.
          flush_if = 1'b1;
          flush_id = 1'b1;
          cnt_d    = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = ST_RUN;
        end
        ST_MC: begin
          if (!ex_mc_done) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_hold     = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          if (ex_branch_taken) begin
            redirect_valid = 1'b1;
            redirect_pc    = ex_branch_target;
            flush_if       = 1'b1;
            flush_id       = 1'b1;
            if (MULTI_FLUSH) begin
              state_d = ST_FLUSH;
              cnt_d   = FLUSH_INIT;
            end
          end else if (ex_mc_start) begin
            if (!ex_mc_done) begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              ex_hold     = 1'b1;
              state_d     = ST_MC;
            end
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_bubble   = 1'b1;
          end else if (id_jump) begin
            redirect_valid = 1'b1;
            redirect_pc    = id_jump_target;
            flush_if       = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      cnt_q          <= '0;
      redirect_count <= '0;
      stall_count    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (redirect_valid && (redirect_count != '1))
        redirect_count <= redirect_count + CNT_ONE;
      if (!pc_write && (stall_count != '1))
        stall_count <= stall_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl: per-cycle vector table plus
// reset, multi-cycle and counter-saturation sequences.
module tb_hazard_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read;
  logic        ex_branch_taken, id_jump, ex_mc_start, ex_mc_done;
  logic [31:0] ex_branch_target, id_jump_target;

  logic        pc_write, if_id_write, flush_if, flush_id;
  logic        ex_bubble, ex_hold, redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  ctrl_state;
  logic [15:0] redirect_count, stall_count;

  logic        s_pc_write, s_if_id_write, s_flush_if, s_flush_id;
  logic        s_ex_bubble, s_ex_hold, s_redirect_valid;
  logic [31:0] s_redirect_pc;
  logic [1:0]  s_ctrl_state;
  logic [3:0]  s_redirect_count, s_stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_flush_ctrl u_dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
    .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .flush_if(flush_if), .flush_id(flush_id),
    .ex_bubble(ex_bubble), .ex_hold(ex_hold),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ctrl_state(ctrl_state),
    .redirect_count(redirect_count), .stall_count(stall_count)
  );

  // Narrow-counter copy so saturation is reachable in a few cycles.
  hazard_flush_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
    .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .flush_if(s_flush_if), .flush_id(s_flush_id),
    .ex_bubble(s_ex_bubble), .ex_hold(s_ex_hold),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .ctrl_state(s_ctrl_state),
    .redirect_count(s_redirect_count), .stall_count(s_stall_count)
  );

  typedef struct {
    string       name;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, mr, br, jp, mcs, mcd;
    logic [31:0] bt, jt;
    logic [6:0]  ctl;
    logic [31:0] rpc;
    logic [1:0]  st;
  } vec_t;

  // {pc_write, if_id_write, flush_if, flush_id, ex_bubble, ex_hold, redirect_valid}
  localparam logic [6:0] E_RUN   = 7'b1100000;
  localparam logic [6:0] E_STALL = 7'b0000100;
  localparam logic [6:0] E_JMP   = 7'b1110001;
  localparam logic [6:0] E_BR    = 7'b1111001;
  localparam logic [6:0] E_FLUSH = 7'b1111000;
  localparam logic [6:0] E_HOLD  = 7'b0000010;
  localparam logic [6:0] E_RST   = 7'b0011100;

  function automatic vec_t mk(
    string n,
    logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
    logic [4:0] rd, logic mr,
    logic br, logic [31:0] bt, logic jp, logic [31:0] jt,
    logic mcs, logic mcd,
    logic [6:0] ctl, logic [31:0] rpc, logic [1:0] st);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.rd = rd; v.mr = mr; v.br = br; v.bt = bt; v.jp = jp;
    v.jt = jt; v.mcs = mcs; v.mcd = mcd;
    v.ctl = ctl; v.rpc = rpc; v.st = st;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2;
    id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_rd = v.rd; ex_mem_read = v.mr;
    ex_branch_taken = v.br; ex_branch_target = v.bt;
    id_jump = v.jp; id_jump_target = v.jt;
    ex_mc_start = v.mcs; ex_mc_done = v.mcd;
  endtask

  task automatic chk_vec(vec_t v);
    chk({v.name, ".ctl"}, 32'({pc_write, if_id_write, flush_if, flush_id,
                               ex_bubble, ex_hold, redirect_valid}),
        32'(v.ctl));
    chk({v.name, ".rpc"}, redirect_pc, v.rpc);
    chk({v.name, ".state"}, 32'(ctrl_state), 32'(v.st));
  endtask

  task automatic step(vec_t v);
    @(negedge clk);
    apply(v);
    #2;
    chk_vec(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[12];
  vec_t idle, jmp40, mcs_v, mcw_v, mcd_v;

  initial begin
    idle  = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0);
    jmp40 = mk("jmp40", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0,
               E_JMP, 32'h40, 0);
    mcs_v = mk("mc_start", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
               E_HOLD, 0, 0);
    mcw_v = mk("mc_wait", 2, 2, 1, 1, 2, 1, 1, 32'h500, 1, 32'h600, 1, 0,
               E_HOLD, 0, 2);
    mcd_v = mk("mc_done", 2, 2, 1, 1, 2, 1, 1, 32'h500, 1, 32'h600, 0, 1,
               E_RUN, 0, 2);

    tbl[0]  = idle;
    tbl[1]  = mk("lu_rs2", 3, 5, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0,
                 E_STALL, 0, 0);
    tbl[2]  = mk("lu_rs1", 7, 1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0,
                 E_STALL, 0, 0);
    tbl[3]  = mk("rd_zero", 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0,
                 E_RUN, 0, 0);
    tbl[4]  = mk("no_use", 9, 9, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0,
                 E_RUN, 0, 0);
    tbl[5]  = mk("no_load", 9, 9, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0,
                 E_RUN, 0, 0);
    tbl[6]  = mk("jump", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0,
                 E_JMP, 32'h200, 0);
    tbl[7]  = mk("lu_over_jump", 0, 4, 0, 1, 4, 1, 0, 0, 1, 32'h300, 0, 0,
                 E_STALL, 0, 0);
    tbl[8]  = mk("mc_1cyc", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,
                 E_RUN, 0, 0);
    tbl[9]  = mk("prio_branch", 6, 0, 1, 0, 6, 1, 1, 32'h100, 1, 32'h200,
                 0, 0, E_BR, 32'h100, 0);
    tbl[10] = mk("flush_masked", 6, 0, 1, 0, 6, 1, 1, 32'h300, 1, 32'h400,
                 1, 0, E_FLUSH, 0, 1);
    tbl[11] = idle;

    rst = 1'b1;
    apply(idle);
    #12;
    chk("por.ctl", 32'({pc_write, if_id_write, flush_if, flush_id,
                        ex_bubble, ex_hold, redirect_valid}), 32'(E_RST));
    @(negedge clk);
    rst = 1'b0;

    // Build up some state, then hit reset in the middle of a FLUSH window.
    step(jmp40);
    step(tbl[1]);
    step(mk("br_pre_rst", 0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0, 0, 0,
            E_BR, 32'h80, 0));
    @(negedge clk);
    apply(mk("x", 0, 0, 0, 0, 0, 0, 1, 32'h90, 1, 32'h94, 0, 0,
             E_RST, 0, 0));
    #2;
    chk("pre_rst.state", 32'(ctrl_state), 32'd1);
    rst = 1'b1;
    #1;
    chk_vec(mk("rst_mid_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
               E_RST, 0, 0));
    chk("rst.redirect_count", 32'(redirect_count), 0);
    chk("rst.stall_count", 32'(stall_count), 0);
    @(negedge clk);
    rst = 1'b0;
    apply(idle);
    #2;
    chk_vec(mk("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
               E_RUN, 0, 0));

    // Per-cycle vector table from a fresh reset.
    do_reset();
    for (int i = 0; i < 12; i++) step(tbl[i]);
    @(negedge clk);
    #2;
    chk("tbl.redirect_count", 32'(redirect_count), 2);
    chk("tbl.stall_count", 32'(stall_count), 3);

    // Multi-cycle op: start, three masked wait cycles, release on done.
    do_reset();
    step(mcs_v);
    for (int i = 0; i < 3; i++) step(mcw_v);
    step(mcd_v);
    step(idle);
    chk("mc.stall_count", 32'(stall_count), 4);
    chk("mc.redirect_count", 32'(redirect_count), 0);

    // Reset while waiting on a multi-cycle op.
    step(mcs_v);
    step(mcw_v);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_mc.state", 32'(ctrl_state), 0);
    chk("rst_mid_mc.hold", 32'(ex_hold), 0);
    @(negedge clk);
    rst = 1'b0;
    apply(idle);

    // Counter saturation on the 4-bit copy, no wrap on the 16-bit one.
    do_reset();
    for (int i = 0; i < 20; i++) step(jmp40);
    step(idle);
    chk("sat.redirect16", 32'(redirect_count), 20);
    chk("sat.redirect4", 32'(s_redirect_count), 15);
    step(mcs_v);
    for (int i = 0; i < 19; i++) step(mcw_v);
    step(mcd_v);
    step(jmp40);
    step(jmp40);
    step(idle);
    chk("sat.stall16", 32'(stall_count), 20);
    chk("sat.stall4", 32'(s_stall_count), 15);
    chk("sat.redirect16_b", 32'(redirect_count), 22);
    chk("sat.redirect4_b", 32'(s_redirect_count), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Detects load-use hazards, control redirects (taken branch resolved in EX, jump decoded in ID) and multi-cycle EX operations.
- Drives the flush inputs of the IF/ID and ID/EX flush units, the PC/IF-ID write enables, the EX bubble/hold, and the PC redirect.
- Multi-cycle flush windows and multi-cycle stalls are held by an internal FSM and counter.

Parameters:
- REG_W, 5, register-index width.
- PC_W, 32, program-counter width.
- FLUSH_CYCLES, 2, cycles flush_if/flush_id stay asserted after a taken branch; legal range 1..15.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- id_rs1  in  REG_W  source reg 1 of the instruction in ID.
- id_rs2  in  REG_W  source reg 2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_W  destination reg of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch in EX resolved taken.
- ex_branch_target  in  PC_W  target of that branch.
- id_jump  in  1  unconditional jump decoded in ID.
- id_jump_target  in  PC_W  jump target.
- ex_mc_start  in  1  multi-cycle op (mul/div) begins in EX this cycle.
- ex_mc_done  in  1  multi-cycle op finishes this cycle.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- flush_if  out  1  zero the IF/ID instruction (to flush unit).
- flush_id  out  1  zero the ID/EX instruction (to flush unit).
- ex_bubble  out  1  insert NOP into ID/EX.
- ex_hold  out  1  freeze ID/EX and EX state.
- redirect_valid  out  1  load redirect_pc into PC.
- redirect_pc  out  PC_W  next PC on redirect.
- ctrl_state  out  2  FSM state: 0 RUN, 1 FLUSH, 2 MC_WAIT.
- redirect_count  out  CNT_W  saturating count of redirects (branch + jump).
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0 outside reset.

Behaviour:
- Outputs are combinational from state, counter and inputs. State, counter and perf counters are registered.
- While rst=1 (async):
  - state=RUN, flush counter=0, both perf counters=0.
  - pc_write=0, if_id_write=0, flush_if=1, flush_id=1, ex_bubble=1, ex_hold=0, redirect_valid=0, redirect_pc=0.
- Default outputs, no hazard, RUN: pc_write=1, if_id_write=1, all others 0.
- Load-use hazard = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN evaluates in priority order; the first match wins and lower entries are ignored:
  1. ex_branch_taken: redirect_valid=1, redirect_pc=ex_branch_target, flush_if=1, flush_id=1, pc_write=1.
     - If FLUSH_CYCLES>1: next=FLUSH, counter=FLUSH_CYCLES-1.
     - Otherwise stay in RUN.
  2. ex_mc_start: pc_write=0, if_id_write=0, ex_hold=1; next=MC_WAIT.
     - If ex_mc_done is also 1 (single-cycle completion), stay in RUN with default outputs.
  3. Load-use hazard: pc_write=0, if_id_write=0, ex_bubble=1 for exactly that cycle; stay in RUN.
  4. id_jump: redirect_valid=1, redirect_pc=id_jump_target, flush_if=1; stay in RUN.
- FLUSH:
  - flush_if=1, flush_id=1, pc_write=1, if_id_write=1.
  - ex_branch_taken, id_jump, ex_mc_start and the hazard term are masked (they belong to squashed instructions).
  - Counter decrements each cycle; when counter==1 the next state is RUN.
- MC_WAIT:
  - pc_write=0, if_id_write=0, ex_hold=1; all other inputs masked.
  - On ex_mc_done: that same cycle, ex_hold=0, pc_write=1, if_id_write=1; next=RUN.
  - No timeout.
- Perf counters saturate at all-ones and never wrap:
  - redirect_count increments once per asserted redirect_valid.
  - stall_count increments once per cycle with pc_write=0 while rst=0.
- Reset asserted mid-FLUSH or mid-MC_WAIT forces RUN immediately. No redirect survives reset.
- ex_rd==0 never creates a load-use hazard.

Test Plan:
- Reset check: assert rst mid-cycle -> immediately flush_if=flush_id=ex_bubble=1, pc_write=0, ctrl_state=0, counters=0. Deassert -> pc_write=1, if_id_write=1.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle of pc_write=0, if_id_write=0, ex_bubble=1; stall_count=1. With ex_rd=0 -> no stall.
- Branch with FLUSH_CYCLES=2: ex_branch_taken=1, target=0x0000_0100 -> redirect_valid=1, redirect_pc=0x100, flush_if=flush_id=1 for 2 cycles. A branch_taken pulse in cycle 2 is ignored; redirect_count=1.
- Multi-cycle op: ex_mc_start, then ex_mc_done 4 cycles later -> ex_hold=1 and pc_write=0 for 4 cycles, released in the done cycle; stall_count=4.
- Priority: ex_branch_taken, load-use and id_jump asserted together -> only the branch redirect (pc=branch target), no ex_bubble. id_jump alone -> flush_if=1, flush_id=0.
- Saturation: preload counter to 0xFFFF via repeated redirects -> it stays at 0xFFFF.
